// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned BCD updates
// and leading-zero blanking. Define SSD_HEX_DECODE_EN to show codes 10-15 as hex A-F.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         display;
  logic [DW-1:0]         pending;
  logic                  pending_valid;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            cur_digit;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = 7'b0000001;
      4'd1:    pattern = 7'b1001111;
      4'd2:    pattern = 7'b0010010;
      4'd3:    pattern = 7'b0000110;
      4'd4:    pattern = 7'b1001100;
      4'd5:    pattern = 7'b0100100;
      4'd6:    pattern = 7'b0100000;
      4'd7:    pattern = 7'b0001111;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0000100;
`ifdef SSD_HEX_DECODE_EN
      4'd10:   pattern = 7'b0001000;
      4'd11:   pattern = 7'b1100000;
      4'd12:   pattern = 7'b0110001;
      4'd13:   pattern = 7'b1000010;
      4'd14:   pattern = 7'b0110000;
      4'd15:   pattern = 7'b0111000;
`endif
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  assign tick = (presc == PRESC_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // A digit above 0 is blank only while it and every more significant digit read 0;
  // invalid codes are nonzero, so they stop the blanking run.
  // NOTE: combinational logic uses blocking '=' and assigns every output a default
  // first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (display[4*i +: 4] == 4'd0);
      blank[i]   = lz_blank && zero_above;
    end
  end

  always_comb begin
    cur_digit = display[4*int'(idx) +: 4];
    seg_next  = blank[idx] ? SEG_BLANK : decode7(cur_digit);
    an_next   = ~(NUM_DIGITS'(1) << idx);
  end

  // NOTE: every register here is a plain flop updated with non-blocking '<=', so all
  // state moves together on the edge regardless of statement order. The display and
  // pending holding registers are small enough to reset like any other state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc         <= '0;
      idx           <= '0;
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      seg           <= SEG_BLANK;
      an            <= '1;
      frame_done    <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);

      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end

      if (load) begin
        pending <= bcd_in;
      end

      // The display register only changes on the wrap so a frame is never torn;
      // a load landing on the wrap itself bypasses the pending stage.
      if (wrap) begin
        pending_valid <= 1'b0;
        if (load) begin
          display <= bcd_in;
        end else if (pending_valid) begin
          display <= pending;
        end
      end else if (load) begin
        pending_valid <= 1'b1;
      end

      seg        <= seg_next;
      an         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (NUM_DIGITS=4, REFRESH_DIV=4): one frame is
// 16 cycles; each scenario captures whole frames and compares against hand-made patterns.
module tb_bcd_display_scanner;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S4   = 7'b1001100;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S6   = 7'b0100000;
  localparam logic [6:0] S7   = 7'b0001111;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0000100;
  localparam logic [6:0] SBLK = 7'b1111111;
`ifdef SSD_HEX_DECODE_EN
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SC   = 7'b0110001;
  localparam logic [6:0] SE   = 7'b0110000;
`else
  localparam logic [6:0] SA   = 7'b1111110;
  localparam logic [6:0] SC   = 7'b1111110;
  localparam logic [6:0] SE   = 7'b1111110;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        load;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0] obs_an  [16];
  logic [6:0] obs_seg [16];
  logic       obs_fd  [16];
  logic [6:0] e       [4];

  bcd_display_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .load      (load),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i / 4));
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic align(input int r);
    while (cyc % 16 != r) step(1);
  endtask

  task automatic do_load(input logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    step(1);
    load   = 1'b0;
  endtask

  // Records one full frame, digit 0 first, starting just after a wrap.
  task automatic grab_frame();
    align(0);
    for (int i = 0; i < 16; i++) begin
      step(1);
      obs_an[i]  = an;
      obs_seg[i] = seg;
      obs_fd[i]  = frame_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; lz_blank = 1'b0; bcd_in = '0;
    step(3);
    n_checks++;
    if (seg !== SBLK) begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg, SBLK); end
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst_n = 1'b1;
    cyc = 0;
    step(1);
    n_checks++;
    if (an !== 4'b1110 || seg !== S0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL release: got an=%b seg=%b fd=%b want an=1110 seg=%b fd=0", an, seg, frame_done, S0);
    end
  endtask

  task automatic test_scan();
    do_load(16'h1234);
    grab_frame();
    e = '{S4, S3, S2, S1};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_an[i] !== exp_an(i) || obs_seg[i] !== e[i/4] || obs_fd[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL scan_1234 c%0d: got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                 i, obs_an[i], obs_seg[i], obs_fd[i], exp_an(i), e[i/4], (i == 15));
      end
    end
  endtask

  task automatic test_blanking();
    lz_blank = 1'b1;
    do_load(16'h0042);
    grab_frame();
    e = '{S2, S4, SBLK, SBLK};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_an[i] !== exp_an(i) || obs_seg[i] !== e[i/4]) begin
        n_fail++; $display("FAIL blank_0042 c%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an[i], obs_seg[i], exp_an(i), e[i/4]);
      end
    end
    do_load(16'h0000);
    grab_frame();
    e = '{S0, SBLK, SBLK, SBLK};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_an[i] !== exp_an(i) || obs_seg[i] !== e[i/4]) begin
        n_fail++; $display("FAIL blank_0000 c%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an[i], obs_seg[i], exp_an(i), e[i/4]);
      end
    end
    lz_blank = 1'b0;
    grab_frame();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_seg[i] !== S0) begin
        n_fail++; $display("FAIL lz_live c%0d: got seg=%b want %b", i, obs_seg[i], S0);
      end
    end
  endtask

  task automatic test_tear_free();
    align(8);
    do_load(16'h5678);
    while (cyc % 16 != 0) begin
      step(1);
      n_checks++;
      if (seg !== S0) begin
        n_fail++; $display("FAIL midframe c%0d: got seg=%b want %b", cyc % 16, seg, S0);
      end
    end
    grab_frame();
    e = '{S8, S7, S6, S5};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_an[i] !== exp_an(i) || obs_seg[i] !== e[i/4]) begin
        n_fail++; $display("FAIL show_5678 c%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an[i], obs_seg[i], exp_an(i), e[i/4]);
      end
    end
    do_load(16'h1111);
    step(3);
    do_load(16'h2222);
    grab_frame();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_seg[i] !== S2) begin
        n_fail++; $display("FAIL last_wins c%0d: got seg=%b want %b", i, obs_seg[i], S2);
      end
    end
  endtask

  task automatic test_back_to_back();
    align(0);
    do_load(16'h3333);
    align(15);
    do_load(16'h9876);
    e = '{S6, S7, S8, S9};
    for (int f = 0; f < 2; f++) begin
      grab_frame();
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs_an[i] !== exp_an(i) || obs_seg[i] !== e[i/4] || obs_fd[i] !== (i == 15)) begin
          n_fail++;
          $display("FAIL wrap_load f%0d c%0d: got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                   f, i, obs_an[i], obs_seg[i], obs_fd[i], exp_an(i), e[i/4], (i == 15));
        end
      end
    end
  endtask

  task automatic test_invalid();
    lz_blank = 1'b1;
    do_load(16'h00A0);
    grab_frame();
    e = '{S0, SA, SBLK, SBLK};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_seg[i] !== e[i/4]) begin
        n_fail++; $display("FAIL code_00A0 c%0d: got seg=%b want %b", i, obs_seg[i], e[i/4]);
      end
    end
    do_load(16'h0C0E);
    grab_frame();
    e = '{SE, S0, SC, SBLK};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_seg[i] !== e[i/4]) begin
        n_fail++; $display("FAIL code_0C0E c%0d: got seg=%b want %b", i, obs_seg[i], e[i/4]);
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_reset_midscan();
    align(0);
    do_load(16'h7777);
    align(13);
    rst_n = 1'b0;
    step(1);
    n_checks++;
    if (seg !== SBLK || an !== 4'b1111 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL midscan_reset: got seg=%b an=%b fd=%b want seg=%b an=1111 fd=0", seg, an, frame_done, SBLK);
    end
    step(1);
    rst_n = 1'b1;
    cyc = 0;
    step(1);
    n_checks++;
    if (an !== 4'b1110 || seg !== S0) begin
      n_fail++; $display("FAIL midscan_release: got an=%b seg=%b want an=1110 seg=%b", an, seg, S0);
    end
    for (int f = 0; f < 2; f++) begin
      grab_frame();
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs_an[i] !== exp_an(i) || obs_seg[i] !== S0) begin
          n_fail++; $display("FAIL pending_dropped f%0d c%0d: got an=%b seg=%b want an=%b seg=%b", f, i, obs_an[i], obs_seg[i], exp_an(i), S0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_tear_free();
    test_back_to_back();
    test_invalid();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
